// File: rtl/pulse_stretcher_pkg.sv
// rtl/pulse_stretcher_pkg.sv - shared state encoding and counter-width helper for pulse_stretcher
package pulse_stretcher_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } ps_state_e;

   function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
      return $clog2(((hold_cycles > gap_cycles) ? hold_cycles : gap_cycles) + 1);
   endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - strobe to fixed-width level with queued replay and guaranteed low gap
// Optional: PULSE_STRETCHER_RETRIGGER_EN makes strobes during HOLD extend the level instead of queueing.
module pulse_stretcher
   import pulse_stretcher_pkg::*;
#(
   parameter int HOLD_CYCLES = 8,
   parameter int GAP_CYCLES  = 2,
   parameter int PEND_MAX    = 3
) (
   input  logic                              clk_in,
   input  logic                              rst,
   input  logic                              pulse_in,
   output logic                              level_out,
   output logic                              busy,
   output logic [$clog2(PEND_MAX+1)-1:0]     pend_cnt,
   output logic                              overflow
);

   localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
   localparam int PW = $clog2(PEND_MAX + 1);

   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
   localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);

   ps_state_e         state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [PW-1:0]     pend_d;
   logic              ovf_d;
   logic              queue_req;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_d    = pend_cnt;
      ovf_d     = overflow;
      queue_req = 1'b0;

      case (state_q)
         IDLE: begin
            if (pulse_in) begin
               state_d = HOLD;
               cnt_d   = HOLD_LOAD;
            end
         end

         HOLD: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
            if (pulse_in) begin
               cnt_d = HOLD_LOAD;
            end else if (cnt_q == '0) begin
               state_d = GAP;
               cnt_d   = GAP_LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
`else
            queue_req = pulse_in;
            if (cnt_q == '0) begin
               state_d = GAP;
               cnt_d   = GAP_LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
`endif
         end

         GAP: begin
            if (cnt_q == '0) begin
               // A strobe arriving on the last gap cycle is consumed directly, so the queue nets to pend + pulse - 1.
               if ((pend_cnt != '0) || pulse_in) begin
                  state_d = HOLD;
                  cnt_d   = HOLD_LOAD;
                  if (!pulse_in) begin
                     pend_d = pend_cnt - 1'b1;
                  end
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d     = cnt_q - 1'b1;
               queue_req = pulse_in;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (queue_req) begin
         if (pend_cnt == PEND_FULL) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pend_cnt  <= '0;
         overflow  <= 1'b0;
         level_out <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_cnt  <= pend_d;
         overflow  <= ovf_d;
         level_out <= (state_d == HOLD);
         busy      <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - scoreboard bench for pulse_stretcher against a level-timeline reference model
module tb_pulse_stretcher;

   localparam int H  = 8;
   localparam int G  = 2;
   localparam int PM = 3;
   localparam int PW = $clog2(PM + 1);

   logic          clk_in = 1'b0;
   logic          rst = 1'b1;
   logic          pulse_in = 1'b0;
   logic          level_out;
   logic          busy;
   logic [PW-1:0] pend_cnt;
   logic          overflow;

   pulse_stretcher #(
      .HOLD_CYCLES (H),
      .GAP_CYCLES  (G),
      .PEND_MAX    (PM)
   ) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .pulse_in  (pulse_in),
      .level_out (level_out),
      .busy      (busy),
      .pend_cnt  (pend_cnt),
      .overflow  (overflow)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int cyc;
      int level;
      int busy;
      int pend;
      int ovf;
   } exp_t;

   exp_t sb[$];
   int   starts[$];
   int   m_ovf = 0;
   int   edge_n = 0;
   int   checks = 0;
   int   errors = 0;
   bit   driver_done = 1'b0;

   task automatic chk(input string name, input int cyc, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s edge=%0d got=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   // Reference: every accepted strobe becomes a level window [start, start+H) followed by G low cycles;
   // a level starts at the strobe edge or when the previous window plus gap has ended, whichever is later.
   task automatic model_edge(input bit p, input bit r, input int n);
      exp_t e;
      int   cand;
      int   pending;
      if (r) begin
         starts.delete();
         m_ovf = 0;
      end else if (p) begin
         cand = n;
         if (starts.size() > 0 && starts[$] + H + G > n) cand = starts[$] + H + G;
         pending = 0;
         foreach (starts[i]) if (starts[i] > n) pending++;
         if (cand > n && pending == PM) m_ovf = 1;
         else starts.push_back(cand);
      end
      while (starts.size() > 1 && starts[0] + H + G <= n) void'(starts.pop_front());
      e.cyc = n; e.level = 0; e.busy = 0; e.pend = 0; e.ovf = m_ovf;
      foreach (starts[i]) begin
         if (starts[i] <= n && n < starts[i] + H)     e.level = 1;
         if (starts[i] <= n && n < starts[i] + H + G) e.busy  = 1;
         if (starts[i] > n)                           e.pend++;
      end
      sb.push_back(e);
   endtask

   task automatic step(input bit p, input bit r);
      @(negedge clk_in);
      pulse_in = p;
      rst      = r;
      @(posedge clk_in);
      edge_n++;
      model_edge(p, r, edge_n);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk_in);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("level_out", e.cyc, int'(level_out), e.level);
            chk("busy",      e.cyc, int'(busy),      e.busy);
            chk("pend_cnt",  e.cyc, int'(pend_cnt),  e.pend);
            chk("overflow",  e.cyc, int'(overflow),  e.ovf);
         end
      end
   end

   initial begin : driver
      int rate;
      // Reset held with pulse_in toggling, then one quiet cycle.
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      idle(1);
      // Single strobe.
      step(1'b1, 1'b0);
      idle(15);
      // Three strobes two cycles apart: back-to-back replay.
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0);
         step(1'b0, 1'b0);
      end
      idle(35);
      // Five strobes during one HOLD: saturation and sticky overflow.
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
      idle(50);
      // Strobe landing on the last gap cycle with nothing queued.
      step(1'b1, 1'b0);
      idle(H + G - 1);
      step(1'b1, 1'b0);
      idle(25);
      // Reset mid-HOLD with two strobes queued.
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      idle(1);
      step(1'b0, 1'b1);
      idle(20);
      // Randomized traffic with varying density and rare resets.
      rate = 4;
      for (int i = 0; i < 3000; i++) begin
         if (i % 250 == 0) rate = int'($urandom_range(1, 12));
         step(($urandom_range(0, rate) == 0), ($urandom_range(0, 599) == 0));
      end
      idle(40);
      driver_done = 1'b1;
   end

   initial begin : finisher
      int guard;
      guard = 0;
      while (!driver_done && guard < 20000) begin
         @(posedge clk_in);
         guard++;
      end
      chk("driver_completed", guard, int'(driver_done), 1);
      @(negedge clk_in);
      #1;
      chk("scoreboard_drained", edge_n, sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Converts single-cycle strobes into clean, fixed-width high levels with a guaranteed low gap between them, so each strobe survives slow or edge-detecting consumers, including the three-flop rising-edge pulse extractors on our reset and button paths. It is the inverse of the level-to-pulse path: pulse in, timed level out. Strobes arriving while an output level is in progress are queued in a saturating pending counter and replayed in order.

## Interface
- HOLD_CYCLES, 8, cycles `level_out` stays high per accepted strobe; legal range ≥2 so a downstream edge detector sees two consecutive high samples.
- GAP_CYCLES, 2, minimum low cycles after each high level; legal range ≥1.
- PEND_MAX, 3, maximum queued strobes; legal range ≥1.
- clk_in  input  1  single clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- pulse_in  input  1  strobe; each high cycle is one request.
- level_out  output  1  stretched level, registered.
- busy  output  1  high in HOLD or GAP.
- pend_cnt  output  $clog2(PEND_MAX+1)  queued strobes not yet played.
- overflow  output  1  sticky; set when a strobe is dropped because the queue is full.

## Operation
- FSM states: IDLE, HOLD, GAP. One down-counter `cnt` of width $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1).
- Reset: state IDLE, cnt 0, level_out 0, busy 0, pend_cnt 0, overflow 0. Reset asserted mid-HOLD/GAP aborts immediately; the queue is discarded.
- IDLE: pulse_in=1 → HOLD, cnt=HOLD_CYCLES-1, level_out=1 next cycle.
- HOLD: cnt decrements; at cnt=0 → GAP, cnt=GAP_CYCLES-1, level_out=0.
- GAP: cnt decrements; at cnt=0: if pend_cnt>0 or pulse_in=1 → HOLD (reload HOLD_CYCLES-1), else → IDLE.
- Queueing: pulse_in=1 in HOLD or GAP increments pend_cnt, except a strobe consumed by the GAP→HOLD transition in the same cycle.
- Net update on the GAP→HOLD transition: pend_cnt_next = pend_cnt + pulse_in − 1.
- Saturation: increment with pend_cnt=PEND_MAX drops the strobe, sets overflow, and leaves pend_cnt unchanged. overflow clears only on rst.
- busy = (state != IDLE), registered alongside level_out.

## Timing
- Latency: strobe sampled at edge k → level_out high from edge k+1 through edge k+HOLD_CYCLES, low for the following GAP_CYCLES edges.
- Back-to-back queued strobes: period exactly HOLD_CYCLES+GAP_CYCLES, with no IDLE cycle inserted.
- Strobe in the same cycle the FSM returns to IDLE is handled as an IDLE strobe on the next edge only if still high. Otherwise it was already counted in GAP per the rules above; no strobe is ever lost or double-counted except on overflow.
- pend_cnt, overflow, and busy update on the same edge as the triggering state change.

## Configuration
- PULSE_STRETCHER_RETRIGGER_EN defined: pulse_in=1 during HOLD reloads cnt=HOLD_CYCLES-1, extending the current level, and is not queued. Strobes during GAP still queue.
- Undefined, the default: strobes during HOLD queue as described above; the HOLD length is always exactly HOLD_CYCLES.

## Structure
- Shared package `pulse_stretcher_pkg`: state enum (IDLE, HOLD, GAP) and a `clog2`-based width helper constant function.
- Single flat module; the FSM and counters are too small to justify a sub-module.

## Test plan
- Reset value check: hold rst 3 cycles with pulse_in toggling → all outputs 0 throughout and one cycle after release.
- Single strobe, HOLD=8, GAP=2: pulse_in at edge 10 → level_out high edges 11–18, low 19–20, busy low from edge 21, pend_cnt stays 0.
- Queue, PEND_MAX=3: strobes at edges 10, 12, 14 → three 8-high/2-low periods back-to-back starting edge 11; pend_cnt sequence 1, 2, 1, 0.
- Overflow: five strobes during the first HOLD → pend_cnt saturates at 3, overflow=1 at the fifth strobe's edge, exactly four levels produced, overflow still 1 afterwards.
- Boundary: strobe in the last GAP cycle with pend_cnt=0 → HOLD restarts the next edge, pend_cnt stays 0, no IDLE cycle.
- Mid-operation reset: rst at HOLD cycle 4 with pend_cnt=2 → next edge level_out=0, pend_cnt=0, state IDLE; with RETRIGGER_EN, a strobe at HOLD cycle 5 extends the high level to 13 cycles total.
